elastic_pipe_chain: RTL and testbench

Parametrised elastic pipeline register: a chain of DEPTH stages, each WIDTH bits wide, carrying a valid/ready handshake, synchronous flush and optional per-stage skid buffering. It replaces plain enable-gated resettable flops between processor pipeline stages, so that stalls propagate by backpressure instead of a global enable. It sits between producer and consumer stages, for example fetch→decode or execute→memory.

---
 rtl/elastic_pipe_pkg.sv | 18 +
 rtl/elastic_pipe_stage.sv | 135 +++++++++++++
 rtl/elastic_pipe_chain.sv | 60 ++++++
 tb/tb_elastic_pipe_chain.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/elastic_pipe_pkg.sv
// Shared types and helpers for the elastic pipeline chain.
// The skid build is selected with the ELASTIC_PIPE_SKID_EN macro.
package elastic_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKID
    } stage_state_t;

    localparam int unsigned CNT_W = 2;

    // Occupancy must hold 0..2*depth, the skid-build maximum.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One elastic stage: valid/ready register with synchronous flush.
// ELASTIC_PIPE_SKID_EN adds a skid register and makes in_ready registered.
module elastic_pipe_stage
    import elastic_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    stage_state_t     state_q, state_d;
    logic             valid_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             in_fire, out_fire;

    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign count     = count_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = valid_q & out_ready;

`ifdef ELASTIC_PIPE_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;

    // Ready depends only on registered state, breaking the ready chain.
    assign in_ready = (state_q != ST_SKID);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_FULL;
                    main_d  = in_data;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = ST_SKID;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_fire) begin
                    state_d = ST_FULL;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Squash wins; data registers keep their old contents.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_q <= '0;
        end else begin
            skid_q <= skid_d;
        end
    end
`else
    // Single register: a full stage may refill in the cycle it drains.
    assign in_ready = (state_q == ST_EMPTY) | out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_FULL;
                    main_d  = in_data;
                end
            end
            ST_FULL: begin
                if (in_fire) begin
                    main_d = in_data;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
        end
    end
`endif

    always_comb begin
        count_d = CNT_W'(0);
        case (state_d)
            ST_FULL: count_d = CNT_W'(1);
            ST_SKID: count_d = CNT_W'(2);
            default: count_d = CNT_W'(0);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            count_q <= '0;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != ST_EMPTY);
            count_q <= count_d;
            main_q  <= main_d;
        end
    end

endmodule

// File: rtl/elastic_pipe_chain.sv
// Chain of DEPTH elastic stages with summed occupancy.
// ELASTIC_PIPE_SKID_EN selects skid-buffered stages (capacity 2*DEPTH).
module elastic_pipe_chain
    import elastic_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1,
    localparam int unsigned OCC_W = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic             v   [DEPTH+1];
    logic             r   [DEPTH+1];
    logic [WIDTH-1:0] d   [DEPTH+1];
    logic [CNT_W-1:0] cnt [DEPTH];
    logic [OCC_W-1:0] occ_sum;

    assign v[0]      = in_valid;
    assign d[0]      = in_data;
    assign in_ready  = r[0];
    assign out_valid = v[DEPTH];
    assign out_data  = d[DEPTH];
    assign r[DEPTH]  = out_ready;
    assign occupancy = occ_sum;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        elastic_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .in_valid (v[i]),
            .in_ready (r[i]),
            .in_data  (d[i]),
            .out_valid(v[i+1]),
            .out_ready(r[i+1]),
            .out_data (d[i+1]),
            .count    (cnt[i])
        );
    end

    always_comb begin
        occ_sum = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + OCC_W'(cnt[i]);
        end
    end

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Self-checking bench for elastic_pipe_chain, DEPTH=3, WIDTH=8, both builds.
module tb_elastic_pipe_chain;

    localparam int DEPTH = 3;
    localparam int WIDTH = 8;
    localparam int OW    = $clog2(2 * DEPTH + 1);
`ifdef ELASTIC_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
    localparam int CAP  = 6;
`else
    localparam bit SKID = 1'b0;
    localparam int CAP  = 3;
`endif

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_data;
    logic [OW-1:0]    occupancy;

    always #5 clk = ~clk;

    elastic_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    int checks = 0;
    int errors = 0;

    // Reference: each stage is a small FIFO of capacity 1 or 2.
    int         msz  [DEPTH];
    logic [7:0] mdat [DEPTH][2];
    bit         mrdy [DEPTH+1];
    bit         fin  [DEPTH];
    bit         ofire;
    int         pushes, pops, flushed;

    bit         s_ir, s_ov;
    logic [7:0] s_od;
    int         s_occ;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) msz[k] = 0;
        pushes  = 0;
        pops    = 0;
        flushed = 0;
    endtask

    // Called just after inputs are driven at a falling edge; returns at the next one.
    task automatic cycle();
        logic [7:0] fr [DEPTH];
        int tot;
        #1;
        s_ir  = in_ready;
        s_ov  = out_valid;
        s_od  = out_data;
        s_occ = int'(occupancy);
        mrdy[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--)
            mrdy[k] = SKID ? (msz[k] < 2) : (msz[k] == 0 || mrdy[k+1]);
        for (int k = 0; k < DEPTH; k++)
            fin[k] = ((k == 0) ? bit'(in_valid) : (msz[k-1] > 0)) && mrdy[k];
        ofire = (msz[DEPTH-1] > 0) && out_ready;

        chk("in_ready", int'(s_ir), int'(mrdy[0]));
        chk("out_valid", int'(s_ov), int'(msz[DEPTH-1] > 0));
        if (msz[DEPTH-1] > 0) chk("out_data", int'(s_od), int'(mdat[DEPTH-1][0]));
        chk("occupancy", s_occ, pushes - pops - flushed);

        @(posedge clk);
        if (ofire) pops++;
        if (flush) begin
            tot = 0;
            for (int k = 0; k < DEPTH; k++) tot += msz[k];
            flushed += tot - (ofire ? 1 : 0);
            for (int k = 0; k < DEPTH; k++) msz[k] = 0;
        end else begin
            for (int k = 0; k < DEPTH; k++) fr[k] = mdat[k][0];
            for (int k = 0; k < DEPTH; k++) begin
                if ((k < DEPTH - 1) ? fin[k+1] : ofire) begin
                    mdat[k][0] = mdat[k][1];
                    msz[k]--;
                end
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (fin[k]) begin
                    mdat[k][msz[k]] = (k == 0) ? in_data : fr[k-1];
                    msz[k]++;
                end
            end
            if (fin[0]) pushes++;
        end
        @(negedge clk);
    endtask

    initial begin
        int obs [8];
        int peak, acc, nv, n, aa, hits, lat;
        int got [16];

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        model_clear();
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_occupancy", int'(occupancy), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Three back-to-back pushes with the consumer always ready.
        out_ready = 1'b1;
        peak = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 3);
            in_data  = (c == 0) ? 8'h11 : (c == 1) ? 8'h22 : 8'h33;
            cycle();
            obs[c] = s_ov ? int'(s_od) : -1;
            if (s_occ > peak) peak = s_occ;
        end
        chk("lat_c2_idle", obs[2], -1);
        chk("lat_c3", obs[3], 'h11);
        chk("lat_c4", obs[4], 'h22);
        chk("lat_c5", obs[5], 'h33);
        chk("lat_c6_idle", obs[6], -1);
        chk("lat_peak_occ", peak, 3);

        // Fill with consumer stalled; count accepted entries.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        nv = 1; acc = 0;
        for (int c = 0; c < 12; c++) begin
            in_data = 8'(nv);
            cycle();
            if (s_ir) begin acc++; nv++; end
        end
        chk("fill_accepted", acc, CAP);
        chk("fill_in_ready", int'(s_ir), 0);
        chk("fill_occ", s_occ, CAP);

        // Drain in order.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
`ifdef ELASTIC_PIPE_SKID_EN
            if (c == 0) chk("drain_ready_registered", int'(s_ir), 0);
`else
            if (c == 0) chk("drain_ready_comb", int'(s_ir), 1);
`endif
            if (s_ov && n < 16) begin got[n] = int'(s_od); n++; end
        end
        chk("drain_count", n, CAP);
        for (int i = 0; i < CAP; i++) chk("drain_order", got[i], i + 1);

        // Full chain, toggled consumer: one transfer per ready-high cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 10; c++) begin in_data = 8'(8'h40 + c); cycle(); end
        hits = 0;
        for (int c = 0; c < 8; c++) begin
            out_ready = c[0];
            in_data   = 8'(8'h60 + c);
            cycle();
            if (s_ov && out_ready) hits++;
        end
        chk("toggle_transfers", hits, 4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) cycle();

        // Flush a full chain while offering 0xAA.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 10; c++) begin in_data = 8'(c + 1); cycle(); end
        flush   = 1'b1;
        in_data = 8'hAA;
        cycle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        aa = 0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (c == 0) begin
                chk("flush_occ", s_occ, 0);
                chk("flush_out_valid", int'(s_ov), 0);
            end
            if (s_ov && s_od == 8'hAA) aa++;
        end
        chk("flush_no_aa", aa, 0);

        // Random valid/ready/flush stress.
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                             : ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 63) == 0);
            cycle();
        end
        flush = 1'b0;

        // Asynchronous reset between edges while entries are held.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin in_data = 8'($urandom); cycle(); end
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_occupancy", int'(occupancy), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // First push after reset emerges DEPTH cycles later.
        out_ready = 1'b1;
        lat = -1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 0);
            in_data  = 8'h5A;
            cycle();
            if (s_ov && lat < 0) begin
                lat = c;
                chk("post_rst_data", int'(s_od), 'h5A);
            end
        end
        chk("post_rst_latency", lat, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
